// File: rtl/neosd_card_cmd.sv
// Card-side SD CMD line engine: receives and CRC-checks 48-bit host commands,
// hands index/argument to a handler and serialises its R1/R2/R3/R6/R7 reply.
module neosd_card_cmd #(
  parameter int NCR         = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         sd_clk_i,
  input  logic         sd_cmd_i,
  output logic         sd_cmd_o,
  output logic         sd_cmd_oe,
  output logic         cmd_valid_o,
  output logic [5:0]   cmd_idx_o,
  output logic [31:0]  cmd_arg_o,
  output logic         err_o,
  input  logic         resp_valid_i,
  input  logic [1:0]   resp_mode_i,
  input  logic         resp_crc_en_i,
  input  logic [5:0]   resp_idx_i,
  input  logic [127:0] resp_data_i
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_RX, S_CHECK, S_WAIT, S_TX} state_t;
  localparam logic [7:0] NCR_L = 8'(NCR);

  function automatic logic [6:0] crc_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:3], c[2] ^ fb, c[1:0], fb};
  endfunction

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] clk_sync, cmd_sync;
  logic                   clk_prev, sclk, scmd, rise, fall;
  logic [45:0]            rx_sr;
  logic [135:0]           tx_sr;
  logic [7:0]             bit_cnt, ncr_cnt;
  logic [6:0]             crc;
  logic                   crc_en_q, acc_q;
  logic                   accept, mode_none, resp_long, frame_ok;

  assign sclk      = clk_sync[SYNC_STAGES-1];
  assign scmd      = cmd_sync[SYNC_STAGES-1];
  assign rise      = sclk & ~clk_prev;
  assign fall      = ~sclk & clk_prev;
  assign accept    = cmd_valid_o & resp_valid_i;
  assign mode_none = (resp_mode_i == 2'd0) || (resp_mode_i == 2'd3);
  assign resp_long = (resp_mode_i == 2'd2);
  assign frame_ok  = (rx_sr[7:1] == crc) && rx_sr[0];

  // Equal-depth chains keep CMD aligned with the clock it was launched against.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      clk_sync <= '0;
      cmd_sync <= '1;
      clk_prev <= 1'b0;
    end else begin
      clk_sync[0] <= sd_clk_i;
      cmd_sync[0] <= sd_cmd_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        clk_sync[i] <= clk_sync[i-1];
        cmd_sync[i] <= cmd_sync[i-1];
      end
      clk_prev <= sclk;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (rise && !scmd) state_nxt = S_START;
      S_START: if (rise) state_nxt = scmd ? S_RX : S_IDLE;
      S_RX:    if (rise && bit_cnt == 8'd1) state_nxt = S_CHECK;
      S_CHECK: state_nxt = frame_ok ? S_WAIT : S_IDLE;
      S_WAIT: begin
        if (accept && mode_none)                      state_nxt = S_IDLE;
        else if (fall && acc_q && ncr_cnt == NCR_L)   state_nxt = S_TX;
      end
      S_TX:    if (fall && bit_cnt == 8'd0) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sd_cmd_o    <= 1'b1;
      sd_cmd_oe   <= 1'b0;
      cmd_valid_o <= 1'b0;
      err_o       <= 1'b0;
      cmd_idx_o   <= '0;
      cmd_arg_o   <= '0;
      rx_sr       <= '0;
      tx_sr       <= '0;
      bit_cnt     <= '0;
      ncr_cnt     <= '0;
      crc         <= '0;
      crc_en_q    <= 1'b0;
      acc_q       <= 1'b0;
    end else begin
      err_o <= 1'b0;
      case (state)
        S_IDLE: crc <= '0;
        S_START: if (rise && scmd) begin
          // start bit 0 leaves the zero register unchanged; fold in the 1
          crc     <= crc_step(7'd0, 1'b1);
          bit_cnt <= 8'd46;
        end
        S_RX: if (rise) begin
          rx_sr   <= {rx_sr[44:0], scmd};
          bit_cnt <= bit_cnt - 8'd1;
          if (bit_cnt >= 8'd9) crc <= crc_step(crc, scmd);
        end
        S_CHECK: begin
          if (frame_ok) begin
            cmd_idx_o   <= rx_sr[45:40];
            cmd_arg_o   <= rx_sr[39:8];
            cmd_valid_o <= 1'b1;
            ncr_cnt     <= '0;
            acc_q       <= 1'b0;
          end else begin
            err_o <= 1'b1;
          end
        end
        S_WAIT: begin
          if (fall && ncr_cnt != NCR_L) ncr_cnt <= ncr_cnt + 8'd1;
          if (accept) begin
            cmd_valid_o <= 1'b0;
            acc_q       <= 1'b1;
            crc_en_q    <= resp_crc_en_i;
            crc         <= '0;
            if (resp_long) begin
              tx_sr   <= {1'b0, 6'h3F, resp_data_i[127:8], 9'd0};
              bit_cnt <= 8'd135;
            end else begin
              tx_sr   <= {1'b0, resp_idx_i, resp_data_i[31:0], 97'd0};
              bit_cnt <= 8'd47;
            end
          end else if (fall && acc_q && ncr_cnt == NCR_L) begin
            sd_cmd_o  <= 1'b0;
            sd_cmd_oe <= 1'b1;
            acc_q     <= 1'b0;
          end
        end
        S_TX: if (fall) begin
          // bit_cnt = bits still to drive: content, then 7 CRC bits, then end bit
          if (bit_cnt == 8'd0) begin
            sd_cmd_o  <= 1'b1;
            sd_cmd_oe <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt - 8'd1;
            if (bit_cnt == 8'd1) begin
              sd_cmd_o <= 1'b1;
            end else if (bit_cnt <= 8'd8) begin
              sd_cmd_o <= crc_en_q ? crc[6] : 1'b1;
              crc      <= {crc[5:0], 1'b0};
            end else begin
              sd_cmd_o <= tx_sr[135];
              tx_sr    <= {tx_sr[134:0], 1'b0};
              // R2 CRC skips transmission bit and the 6'h3F field
              if (bit_cnt <= 8'd128) crc <= crc_step(crc, tx_sr[135]);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
